// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: sequencing controller in front of the Enigma rotor
// substitution datapath. Accepts one character at a time, advances the three
// rotor positions with odometer stepping (including the middle-rotor
// double-step), runs one start/done transaction on the datapath and holds the
// substituted result until the consumer takes it.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_load, cfg_pos0..2       load rotor start positions (IDLE only)
//   in_valid, in_ready, in_char input character handshake (0..25 = A..Z)
//   dp_start, dp_char, dp_pos*  datapath request (start pulse, char, positions)
//   dp_done, dp_result          datapath response
//   out_valid, out_ready        result handshake
//   out_char, out_err           result character, invalid-code passthrough flag
//   busy                        controller not in IDLE
//   char_count                  completed valid characters (wraps)
module enigma_step_ctrl #(
  parameter int unsigned NOTCH0 = 21,
  parameter int unsigned NOTCH1 = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [4:0]       cfg_pos0,
  input  logic [4:0]       cfg_pos1,
  input  logic [4:0]       cfg_pos2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_char,
  output logic             dp_start,
  output logic [4:0]       dp_char,
  output logic [4:0]       dp_pos0,
  output logic [4:0]       dp_pos1,
  output logic [4:0]       dp_pos2,
  input  logic             dp_done,
  input  logic [4:0]       dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_char,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] char_count
);

  localparam int unsigned PW = 5;
  localparam logic [PW-1:0] LAST = PW'(25);

  typedef enum logic [2:0] {IDLE, STEP, ISSUE, WAIT, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] pos0, pos1, pos2;
  logic [PW-1:0] char_q;
  logic          step1, step2;
  logic [PW-1:0] nxt0, nxt1, nxt2;

  // Increment modulo 26.
  function automatic logic [PW-1:0] inc26(input logic [PW-1:0] p);
    return (p >= LAST) ? '0 : p + PW'(1);
  endfunction

  // Out-of-range start positions load as 0.
  function automatic logic [PW-1:0] clamp_pos(input logic [PW-1:0] p);
    return (p > LAST) ? '0 : p;
  endfunction

  // Stepping decision from pre-step positions; pos1 notch drives the double-step.
  assign step1 = (pos0 == PW'(NOTCH0)) || (pos1 == PW'(NOTCH1));
  assign step2 = (pos1 == PW'(NOTCH1));
  assign nxt0  = inc26(pos0);
  assign nxt1  = step1 ? inc26(pos1) : pos1;
  assign nxt2  = step2 ? inc26(pos2) : pos2;

  // Held low during reset so acceptance starts the cycle after rst drops.
  assign in_ready = (state == IDLE) && !cfg_load && !rst;
  assign busy     = (state != IDLE);

  // Controller state, rotor positions and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos0       <= '0;
      pos1       <= '0;
      pos2       <= '0;
      char_q     <= '0;
      dp_start   <= 1'b0;
      dp_char    <= '0;
      dp_pos0    <= '0;
      dp_pos1    <= '0;
      dp_pos2    <= '0;
      out_valid  <= 1'b0;
      out_char   <= '0;
      out_err    <= 1'b0;
      char_count <= '0;
    end else begin
      dp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            pos0 <= clamp_pos(cfg_pos0);
            pos1 <= clamp_pos(cfg_pos1);
            pos2 <= clamp_pos(cfg_pos2);
          end else if (in_valid) begin
            if (in_char <= LAST) begin
              char_q <= in_char;
              state  <= STEP;
            end else begin
              // Invalid code bypasses rotors and datapath entirely.
              out_char  <= in_char;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        STEP: begin
          pos0     <= nxt0;
          pos1     <= nxt1;
          pos2     <= nxt2;
          dp_char  <= char_q;
          dp_pos0  <= nxt0;
          dp_pos1  <= nxt1;
          dp_pos2  <= nxt2;
          dp_start <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (dp_done) begin
            out_char  <= dp_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_err) char_count <= char_count + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
